ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit at the front of the pipeline. Issues one-outstanding-request reads on the instruction bus, captures the returned 32-bit word and presents it with its PC to the decode/immediate-generation logic. Handles downstream stall with a single-entry buffer, and redirects from execute, including squashing a request already in flight.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC of the first fetch after reset
- clk  in  1  clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ireq_valid  out  1  instruction bus request valid
- ireq_addr  out  64  request address; always 4-byte aligned
- iresp_addr_ok  in  1  request accepted this cycle
- iresp_data_ok  in  1  read data returned this cycle
- iresp_data  in  32  read data, valid when iresp_data_ok=1
- stall  in  1  decode cannot accept this cycle
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch target
- instr_valid  out  1  instr_raw/instr_pc hold a valid instruction
- instr_raw  out  32  fetched instruction word
- instr_pc  out  64  PC of instr_raw
- instr_exc  out  1  fetch-misaligned exception flag (only with IFETCH_EXC_EN; else tied 0)

## Operation
- Registers: pc (next fetch address), buffer {valid, raw, pc, exc}, FSM state, discard flag.
- FSM states:
  - REQ: ireq_valid=1, ireq_addr=pc. On addr_ok: to WAIT, or stay REQ/IDLE per below if data_ok arrives in the same cycle.
  - WAIT: ireq_valid=0; wait for data_ok.
  - IDLE: buffer full and not draining; no request.
- Transfer to decode: instr_valid && !stall.
- data_ok with discard=0: buffer ← {1, iresp_data, pc, 0}; pc ← pc+4; next state is REQ if the buffer will be free next cycle, else IDLE.
- data_ok with discard=1: data dropped; discard←0; next state REQ at the redirect target.
- IDLE → REQ in the cycle after a transfer empties the buffer.
- Redirect, any state: buffer invalidated in the same edge, pc←redirect_pc.
  - In REQ before addr_ok: ireq_addr stays stable (protocol); discard←1.
  - In WAIT: discard←1.
  - In REQ/IDLE with nothing in flight: next cycle REQ at the new pc.
- A later redirect while discard=1 overwrites the target; the latest redirect wins.
- Redirect and transfer in the same cycle: redirect wins. The instruction in the buffer is counted as not transferred.
- pc+4 wraps modulo 2^64.

## Timing
- Reset values: ireq_valid=0, ireq_addr=RESET_PC, instr_valid=0, instr_raw=0, instr_pc=0, instr_exc=0, discard=0, state=REQ.
- First cycle after reset deasserts: ireq_valid=1, ireq_addr=RESET_PC.
- ireq_valid and ireq_addr are held constant from assertion until addr_ok is sampled high.
- addr_ok and data_ok may coincide, or data_ok may come any number of cycles later.
- Latency: data_ok at edge t → instr_valid=1 from edge t+1.
- Best-case throughput with zero-wait bus: one instruction per 2 cycles.
- Reset mid-request: all state is abandoned; the bus is reset alongside, so no stale data_ok is expected.
- Outputs are registered; no combinational path from stall or redirect to ireq_*.

## Configuration
- IFETCH_EXC_EN defined:
  - A redirect_pc with bits [1:0] ≠ 0 issues no bus request.
  - The buffer loads {valid=1, raw=0, pc=redirect_pc, exc=1} on the next edge, once any in-flight discard completes.
  - Fetch then idles until the next redirect.
- IFETCH_EXC_EN undefined: redirect_pc[1:0] is forced to 0, and instr_exc is constant 0.

## Test plan
- Reset, zero-wait bus (addr_ok=data_ok=1 same cycle), stall=0 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; instr_pc follows; instr_raw equals the returned data.
- Hold addr_ok=0 for 3 cycles → ireq_addr stable at 0x8000_0000 for all 3 cycles; data_ok 2 cycles after addr_ok → instr_valid the cycle after data_ok.
- stall=1 for 5 cycles with buffer full → instr_valid/instr_raw/instr_pc constant, ireq_valid=0; stall drops → next request at pc+4 the cycle after transfer.
- redirect to 0x8000_0100 while in WAIT → returned word never appears on instr_*; next request is 0x8000_0100.
- Redirect and transfer in the same cycle, then a second redirect to 0x8000_0200 while discard=1 → only 0x8000_0200 is fetched.
- With IFETCH_EXC_EN, redirect to 0x8000_0102 → no ireq_valid; instr_valid=1, instr_exc=1, instr_pc=0x8000_0102. Without IFETCH_EXC_EN, the same redirect fetches 0x8000_0100.

Source files
------------

// File: rtl/ifetch_if.sv
// Instruction bus and decode-side handshake for the fetch unit.
interface ifetch_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_raw;
  logic [63:0] instr_pc;
  logic        instr_exc;

  modport master (
    output ireq_valid, ireq_addr, instr_valid, instr_raw, instr_pc, instr_exc,
    input  iresp_addr_ok, iresp_data_ok, iresp_data, stall, redirect, redirect_pc
  );
  modport slave (
    input  ireq_valid, ireq_addr, instr_valid, instr_raw, instr_pc, instr_exc,
    output iresp_addr_ok, iresp_data_ok, iresp_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding bus read, single-entry output buffer, redirect/squash.
// Optional IFETCH_EXC_EN: misaligned redirect targets raise a fetch exception instead of fetching.
module ifetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic      clk,
  input logic      reset,
  ifetch_if.master bus
);
`ifdef IFETCH_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_IDLE} state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] raw;
    logic [63:0] pc;
    logic        exc;
  } entry_t;

  state_t      state;
  entry_t      held;
  logic [63:0] pc, req_addr;
  logic        req_valid, discard, exc_pend;

  logic [63:0] tgt, nxt_pc;
  logic        tgt_mis, nxt_mis;
  logic        xfer, accepted, done, drop, load, pend, restart;

  assign tgt     = EXC_EN ? bus.redirect_pc : (bus.redirect_pc & ~64'h3);
  assign tgt_mis = EXC_EN && (bus.redirect_pc[1:0] != 2'b00);

  always_comb begin
    xfer     = held.valid && !bus.stall && !bus.redirect;
    accepted = req_valid && bus.iresp_addr_ok;
    done     = bus.iresp_data_ok && ((state == S_REQ && accepted) || state == S_WAIT);
    drop     = done && (discard || bus.redirect);
    load     = done && !drop;
    // a request is visible or accepted but its data has not come back yet
    pend     = !done && ((state == S_REQ && req_valid) || state == S_WAIT);
    restart  = drop || (state == S_REQ && !req_valid) ||
               (state == S_IDLE && (bus.redirect || (xfer && !exc_pend)));
    nxt_pc   = bus.redirect ? tgt : pc;
    nxt_mis  = bus.redirect ? tgt_mis : exc_pend;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_REQ;
      held      <= '0;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      req_valid <= 1'b0;
      discard   <= 1'b0;
      exc_pend  <= 1'b0;
    end else begin
      if (bus.redirect) begin
        held.valid <= 1'b0;
        pc         <= tgt;
        exc_pend   <= tgt_mis;
      end else if (xfer) begin
        held.valid <= 1'b0;
      end
      if (accepted) req_valid <= 1'b0;
      if (state == S_REQ && accepted && !bus.iresp_data_ok) state <= S_WAIT;
      if (pend) discard <= discard | bus.redirect;
      if (load) begin
        held  <= '{valid: 1'b1, raw: bus.iresp_data, pc: pc, exc: 1'b0};
        pc    <= pc + 64'd4;
        state <= S_IDLE;
      end
      // start fetching at the (possibly new) target, or park a misaligned target as an exception
      if (restart) begin
        discard <= 1'b0;
        if (nxt_mis) begin
          held      <= '{valid: 1'b1, raw: 32'h0, pc: nxt_pc, exc: 1'b1};
          state     <= S_IDLE;
          req_valid <= 1'b0;
        end else begin
          state     <= S_REQ;
          req_valid <= 1'b1;
          req_addr  <= nxt_pc;
        end
      end
    end
  end

  assign bus.ireq_valid  = req_valid;
  assign bus.ireq_addr   = req_addr;
  assign bus.instr_valid = held.valid;
  assign bus.instr_raw   = held.raw;
  assign bus.instr_pc    = held.pc;
  assign bus.instr_exc   = held.exc;
endmodule

// File: tb/tb_ifetch.sv
// Directed test of ifetch: zero-wait and delayed bus, stall hold, redirects, misaligned target, pc wrap.
module tb_ifetch;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ifetch_if bus();
  ifetch dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_in(input logic aok, input logic dok, input logic [31:0] d);
    bus.iresp_addr_ok = aok;
    bus.iresp_data_ok = dok;
    bus.iresp_data    = d;
  endtask

  task automatic redir(input logic r, input logic [63:0] p);
    bus.redirect    = r;
    bus.redirect_pc = p;
  endtask

  initial begin
    reset = 1'b1;
    bus_in(1'b0, 1'b0, 32'h0);
    redir(1'b0, 64'h0);
    bus.stall = 1'b0;
    step(); step();
    chk("rst_ireq_valid", bus.ireq_valid, 0);
    chk("rst_ireq_addr", bus.ireq_addr, 64'h8000_0000);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_instr_raw", bus.instr_raw, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_instr_exc", bus.instr_exc, 0);
    reset = 1'b0;
    step();
    chk("first_req_valid", bus.ireq_valid, 1);
    chk("first_req_addr", bus.ireq_addr, 64'h8000_0000);

    // zero-wait bus
    bus_in(1'b1, 1'b1, 32'h1111_0000);
    step();
    chk("zw0_valid", bus.instr_valid, 1);
    chk("zw0_raw", bus.instr_raw, 32'h1111_0000);
    chk("zw0_pc", bus.instr_pc, 64'h8000_0000);
    chk("zw0_noreq", bus.ireq_valid, 0);
    bus_in(1'b0, 1'b0, 32'h0);
    step();
    chk("zw1_xfer", bus.instr_valid, 0);
    chk("zw1_req", bus.ireq_valid, 1);
    chk("zw1_addr", bus.ireq_addr, 64'h8000_0004);
    bus_in(1'b1, 1'b1, 32'h2222_0004);
    step();
    chk("zw1_raw", bus.instr_raw, 32'h2222_0004);
    chk("zw1_pc", bus.instr_pc, 64'h8000_0004);
    bus_in(1'b0, 1'b0, 32'h0);
    step();
    chk("zw2_addr", bus.ireq_addr, 64'h8000_0008);

    // addr_ok held low three cycles, data two cycles after acceptance
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", bus.ireq_valid, 1);
      chk("hold_addr", bus.ireq_addr, 64'h8000_0008);
    end
    bus_in(1'b1, 1'b0, 32'h0);
    step();
    chk("wait_noreq", bus.ireq_valid, 0);
    bus_in(1'b0, 1'b0, 32'h0);
    step();
    chk("wait_nodata", bus.instr_valid, 0);
    bus_in(1'b0, 1'b1, 32'h3333_0008);
    bus.stall = 1'b1;
    step();
    chk("lat_valid", bus.instr_valid, 1);
    chk("lat_pc", bus.instr_pc, 64'h8000_0008);

    // stall holds the buffer
    bus_in(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", bus.instr_valid, 1);
      chk("stall_raw", bus.instr_raw, 32'h3333_0008);
      chk("stall_noreq", bus.ireq_valid, 0);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_req", bus.ireq_valid, 1);
    chk("unstall_addr", bus.ireq_addr, 64'h8000_000C);

    // redirect while WAIT squashes the returning word
    bus_in(1'b1, 1'b0, 32'h0);
    step();
    bus_in(1'b0, 1'b0, 32'h0);
    redir(1'b1, 64'h8000_0100);
    step();
    chk("rdw_noreq", bus.ireq_valid, 0);
    redir(1'b0, 64'h0);
    bus_in(1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    chk("rdw_squash", bus.instr_valid, 0);
    chk("rdw_req", bus.ireq_valid, 1);
    chk("rdw_addr", bus.ireq_addr, 64'h8000_0100);
    bus_in(1'b1, 1'b1, 32'h4444_0100);
    step();
    chk("rdw_pc", bus.instr_pc, 64'h8000_0100);
    chk("rdw_raw", bus.instr_raw, 32'h4444_0100);

    // redirect beats transfer, then latest redirect wins while discarding
    bus_in(1'b0, 1'b0, 32'h0);
    redir(1'b1, 64'h8000_0180);
    step();
    chk("rx_dropped", bus.instr_valid, 0);
    chk("rx_addr", bus.ireq_addr, 64'h8000_0180);
    redir(1'b1, 64'h8000_0190);
    step();
    chk("rx_stable1", bus.ireq_addr, 64'h8000_0180);
    redir(1'b1, 64'h8000_0200);
    step();
    chk("rx_stable2", bus.ireq_addr, 64'h8000_0180);
    redir(1'b0, 64'h0);
    bus_in(1'b1, 1'b1, 32'hBAD0_0180);
    step();
    chk("rx_squash", bus.instr_valid, 0);
    chk("rx_latest", bus.ireq_addr, 64'h8000_0200);
    bus_in(1'b1, 1'b1, 32'h5555_0200);
    step();
    chk("rx_pc", bus.instr_pc, 64'h8000_0200);
    chk("rx_raw", bus.instr_raw, 32'h5555_0200);

    // misaligned redirect target
    bus_in(1'b0, 1'b0, 32'h0);
    bus.stall = 1'b1;
    redir(1'b1, 64'h8000_0102);
    step();
    redir(1'b0, 64'h0);
`ifdef IFETCH_EXC_EN
    chk("mis_noreq", bus.ireq_valid, 0);
    chk("mis_valid", bus.instr_valid, 1);
    chk("mis_exc", bus.instr_exc, 1);
    chk("mis_pc", bus.instr_pc, 64'h8000_0102);
    bus.stall = 1'b0;
    step();
    chk("mis_idle1", bus.ireq_valid, 0);
    step();
    chk("mis_idle2", bus.ireq_valid, 0);
`else
    chk("mis_req", bus.ireq_valid, 1);
    chk("mis_addr", bus.ireq_addr, 64'h8000_0100);
    chk("mis_exc", bus.instr_exc, 0);
    bus.stall = 1'b0;
    bus_in(1'b1, 1'b1, 32'h6666_0100);
    step();
    chk("mis_pc", bus.instr_pc, 64'h8000_0100);
    bus_in(1'b0, 1'b0, 32'h0);
`endif

    // pc wraps past the top of the address space
    redir(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    redir(1'b0, 64'h0);
    chk("wrap_req", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    bus_in(1'b1, 1'b1, 32'h7777_FFFC);
    step();
    chk("wrap_pc", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    bus_in(1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_next", bus.ireq_addr, 64'h0);

    // reset mid-request abandons everything immediately
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", bus.ireq_valid, 0);
    chk("mid_rst_addr", bus.ireq_addr, 64'h8000_0000);
    chk("mid_rst_valid", bus.instr_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
